// File: rtl/uart_rx_parser.sv
// uart_rx_parser: UART receiver plus a decimal, comma-separated detection-frame parser.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit between D7 and stop.
module uart_rx_parser #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [2:0] imgID,
  output logic [9:0] accuracy,
  output logic [8:0] bbx1,
  output logic [8:0] bby1,
  output logic [8:0] bbx2,
  output logic [8:0] bby2,
  output logic       frameValid,
  output logic       frameError
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
`ifdef UART_RX_PARITY_EN
    B_PARITY,
`endif
    B_STOP
  } bstate_t;

  typedef enum logic {P_FIELD, P_SKIP} pstate_t;
  typedef enum logic [2:0] {A_NONE, A_DIGIT, A_NEXT, A_COMMIT, A_REJECT} act_t;

  logic          rx_meta, rx_sync;
  logic          armed;
  bstate_t       b_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid, byte_err;
  logic          stop_ok;

`ifdef UART_RX_PARITY_EN
  logic par_ok;
  assign stop_ok = rx_sync & par_ok;
`else
  assign stop_ok = rx_sync;
`endif

  // Bit engine. armed records that the line has been seen high, so a start is
  // only taken on a genuine high-to-low transition (also after reset or a break).
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the synchronizer resets low so a line held low through reset
      // cannot look like an idle-high line followed by a start edge.
      rx_meta    <= 1'b0;
      rx_sync    <= 1'b0;
      armed      <= 1'b0;
      b_state    <= B_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every branch reads this cycle's state.
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (b_state)
        B_IDLE: begin
          cnt <= '0;
          if (rx_sync) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed   <= 1'b0;
            b_state <= B_START;
          end
        end
        B_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            b_state <= rx_sync ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        B_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              b_state <= B_PARITY;
`else
              b_state <= B_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        B_PARITY: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_ok  <= ~((^shreg) ^ rx_sync);
            b_state <= B_STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        B_STOP: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            b_state <= B_IDLE;
            armed   <= rx_sync;
            if (stop_ok) byte_valid <= 1'b1;
            else         byte_err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: b_state <= B_IDLE;
      endcase
    end
  end

  pstate_t     p_state;
  act_t        act;
  logic [10:0] acc;
  logic [1:0]  ndig;
  logic [2:0]  field_idx;
  logic [2:0]  sh_img;
  logic [9:0]  sh_acc;
  logic [8:0]  sh_x1, sh_y1, sh_x2;
  logic        is_digit, range_ok;

  assign is_digit = (shreg >= 8'h30) && (shreg <= 8'h39);

  always_comb begin
    case (field_idx)
      3'd0:    range_ok = (acc <= 11'd7);
      3'd1:    range_ok = 1'b1;
      default: range_ok = (acc <= 11'd511);
    endcase
  end

  // Classify the delivered byte into a single parser action.
  always_comb begin
    act = A_NONE;
    if (p_state == P_FIELD) begin
      if (byte_err) begin
        act = A_REJECT;
      end else if (byte_valid) begin
        if (is_digit) begin
          act = (ndig == 2'd3) ? A_REJECT : A_DIGIT;
        end else if (shreg == CH_CR) begin
          act = A_NONE;
        end else if (shreg == CH_COMMA) begin
          act = (ndig == 2'd0 || !range_ok || field_idx == 3'd5) ? A_REJECT : A_NEXT;
        end else if (shreg == CH_LF) begin
          if (field_idx == 3'd0 && ndig == 2'd0) act = A_NONE;
          else act = (ndig == 2'd0 || !range_ok || field_idx != 3'd5) ? A_REJECT : A_COMMIT;
        end else begin
          act = A_REJECT;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_state    <= P_FIELD;
      acc        <= '0;
      ndig       <= '0;
      field_idx  <= '0;
      sh_img     <= '0;
      sh_acc     <= '0;
      sh_x1      <= '0;
      sh_y1      <= '0;
      sh_x2      <= '0;
      imgID      <= '0;
      accuracy   <= '0;
      bbx1       <= '0;
      bby1       <= '0;
      bbx2       <= '0;
      bby2       <= '0;
      frameValid <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      frameError <= 1'b0;
      case (act)
        A_DIGIT: begin
          acc  <= acc * 11'd10 + {7'd0, shreg[3:0]};
          ndig <= ndig + 2'd1;
        end
        A_NEXT: begin
          case (field_idx)
            3'd0:    sh_img <= acc[2:0];
            3'd1:    sh_acc <= acc[9:0];
            3'd2:    sh_x1  <= acc[8:0];
            3'd3:    sh_y1  <= acc[8:0];
            default: sh_x2  <= acc[8:0];
          endcase
          field_idx <= field_idx + 3'd1;
          acc       <= '0;
          ndig      <= '0;
        end
        A_COMMIT: begin
          imgID      <= sh_img;
          accuracy   <= sh_acc;
          bbx1       <= sh_x1;
          bby1       <= sh_y1;
          bbx2       <= sh_x2;
          bby2       <= acc[8:0];
          frameValid <= 1'b1;
          field_idx  <= '0;
          acc        <= '0;
          ndig       <= '0;
        end
        A_REJECT: begin
          frameError <= 1'b1;
          field_idx  <= '0;
          acc        <= '0;
          ndig       <= '0;
          // A rejecting newline already ends the line, so no skipping is needed.
          p_state    <= (byte_valid && shreg == CH_LF) ? P_FIELD : P_SKIP;
        end
        default: begin
          if (p_state == P_SKIP && byte_valid && shreg == CH_LF) p_state <= P_FIELD;
        end
      endcase
    end
  end

endmodule
